// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one iteration per clock, with the architectural HI/LO registers updated only on completion.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            is_div;
    logic            neg_lo;
    logic            neg_hi;
    logic            div_zero;
    logic [W-1:0]    addend;
    logic [W-1:0]    dividend;
    logic [W-1:0]    work_hi;
    logic [W-1:0]    work_lo;

    logic            a_neg;
    logic            b_neg;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic            div_ge;
    logic [W-1:0]    div_rem;
    logic [W-1:0]    step_hi;
    logic [W-1:0]    step_lo;
    logic [2*W-1:0]  prod_mag;
    logic [2*W-1:0]  prod;
    logic [W-1:0]    res_hi;
    logic [W-1:0]    res_lo;

    // Signed ops run on magnitudes; result signs are reapplied at the end.
    always_comb begin
        a_neg = ~op[0] & src_a[W-1];
        b_neg = ~op[0] & src_b[W-1];
        mag_a = a_neg ? -src_a : src_a;
        mag_b = b_neg ? -src_b : src_b;
    end

    // work_lo holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first).
    always_comb begin
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, addend} : '0);
        div_shift = {work_hi, work_lo[W-1]};
        div_ge    = div_shift >= {1'b0, addend};
        div_rem   = div_shift[W-1:0] - addend;
        if (is_div) begin
            step_hi = div_ge ? div_rem : div_shift[W-1:0];
            step_lo = {work_lo[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], work_lo[W-1:1]};
        end
    end

    always_comb begin
        prod_mag = {step_hi, step_lo};
        prod     = neg_lo ? -prod_mag : prod_mag;
        res_hi   = prod[2*W-1:W];
        res_lo   = prod[W-1:0];
        if (is_div) begin
            if (div_zero) begin
                res_hi = dividend;
                res_lo = '1;
            end else begin
                res_hi = neg_hi ? -step_hi : step_hi;
                res_lo = neg_lo ? -step_lo : step_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            addend   <= '0;
            dividend <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        count    <= '0;
                        is_div   <= op[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= op[1] & a_neg;
                        div_zero <= (src_b == '0);
                        dividend <= src_a;
                        work_hi  <= '0;
                        addend   <= op[1] ? mag_b : mag_a;
                        work_lo  <= op[1] ? mag_a : mag_b;
                    end else begin
                        if (mthi) hi <= src_a;
                        if (mtlo) lo <= src_a;
                    end
                end
                RUN: begin
                    work_hi <= step_hi;
                    work_lo <= step_lo;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes reference results into a queue,
// a negedge monitor checks done/busy/hi/lo every cycle against the queue and the HI/LO model.
module tb_mult_div_unit;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          cycle = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;
    int          busy_start = -1;
    int          busy_end = -1;
    int          free_edge = 0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference: plain 64-bit integer arithmetic; SV / and % truncate toward zero.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int              sa;
        int              sbv;
        longint          la;
        longint          lb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        sa  = a;
        sbv = b;
        la  = sa;
        lb  = sbv;
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (o)
            2'b00: begin
                q = la * lb;
                return q;
            end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                q = la / lb;
                r = la % lb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    task automatic waitCycle(input int c);
        while (cycle < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic mh, input logic ml);
        logic        accept;
        logic        idle;
        logic [63:0] r;
        exp_t        e;
        @(posedge clk);
        #2;
        start = st;
        op    = o;
        src_a = a;
        src_b = b;
        mthi  = mh;
        mtlo  = ml;
        idle   = (cycle + 1 >= free_edge);
        accept = st && idle;
        if (accept) begin
            r     = ref_model(o, a, b);
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.due = cycle + 33;
            sb.push_back(e);
            busy_start = cycle + 1;
            busy_end   = cycle + 33;
            free_edge  = cycle + 34;
        end
        @(posedge clk);
        #1;
        if (!accept && idle) begin
            if (mh) arch_hi = a;
            if (ml) arch_lo = a;
        end
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        op    = 2'($urandom);
        src_a = $urandom;
        src_b = $urandom;
    endtask

    task automatic runBack(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        waitCycle(free_edge - 2);
        applyStimulus(1'b1, o, a, b, 1'b0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // A result is due on exactly one cycle; every other cycle done must be low and HI/LO must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cycle) begin
                checkOutput("done_pulse", {31'b0, done}, 32'd1);
                checkOutput("result_hi", hi, sb[0].hi);
                checkOutput("result_lo", lo, sb[0].lo);
                arch_hi = sb[0].hi;
                arch_lo = sb[0].lo;
                void'(sb.pop_front());
            end else begin
                checkOutput("done_quiet", {31'b0, done}, 32'd0);
                checkOutput("hold_hi", hi, arch_hi);
                checkOutput("hold_lo", lo, arch_lo);
            end
            checkOutput("busy", {31'b0, busy}, {31'b0, (cycle >= busy_start) && (cycle < busy_end)});
        end
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected finish at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        runBack(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        runBack(2'b00, 32'hFFFFFFFD, 32'd7);
        runBack(2'b10, 32'hFFFFFFF9, 32'd2);
        runBack(2'b11, 32'd100, 32'd7);
        runBack(2'b11, 32'd100, 32'd0);
        runBack(2'b10, 32'h80000000, 32'hFFFFFFFF);
        runBack(2'b10, 32'hFFFFFF00, 32'd0);

        // Requests during RUN must be dropped; moves while idle land immediately.
        runBack(2'b01, 32'd5, 32'd6);
        waitCycle(busy_start + 4);
        applyStimulus(1'b1, 2'b11, 32'd9, 32'd3, 1'b1, 1'b0);
        waitCycle(free_edge);
        applyStimulus(1'b0, 2'b00, 32'h1234, 32'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 2'b00, 32'hABCD, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 32'h5555AAAA, 32'd0, 1'b1, 1'b1);
        applyStimulus(1'b1, 2'b01, 32'd3, 32'd4, 1'b1, 1'b1);

        // Abort a divide with reset ten cycles in.
        runBack(2'b11, 32'd1000, 32'd7);
        waitCycle(busy_start + 9);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_done", {31'b0, done}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        sb.delete();
        arch_hi    = '0;
        arch_lo    = '0;
        busy_start = -1;
        busy_end   = -1;
        free_edge  = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        waitCycle(cycle + 40);
        runBack(2'b01, 32'd2, 32'd3);

        for (int i = 0; i < 25; i++) begin
            waitCycle(free_edge - 2 + int'($urandom_range(0, 2)));
            applyStimulus(1'b1, 2'($urandom_range(0, 3)), pick(), pick(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                waitCycle(busy_start + 10);
                applyStimulus(1'b1, 2'($urandom_range(0, 3)), pick(), pick(), 1'b1, 1'b1);
            end
        end

        waitCycle(free_edge + 2);
        checkOutput("queue_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
